pc_fetch_unit: RTL
==================

// Module: pc_fetch_unit
// PURPOSE
//   Program counter and instruction fetch stage of the CPU. Fetches an instruction from instruction
//   memory over a req/ack handshake and holds it stable for control_unit to decode. It then consumes
//   control_unit's pc_control (plus rs_data for JR) and computes the next PC. It is the consumer end
//   of the pc_control interface and the producer of the instruction bus.
// PARAMETERS
//   RESET_PC   32'h0040_0000  PC value loaded on reset
//   TIMEOUT    8              cycles of FETCH without imem_ack before fetch_err sets (>=1)
// PORTS
//   clk          in   1   single clock, rising edge
//   rst          in   1   reset, asynchronous, active-low
//   pc_control   in   4   from control_unit: 0 seq, 1 J, 2 JR, 3 branch taken, 4..15 = seq
//   rs_data      in   32  register-file rs read data (JR target)
//   stall        in   1   hold current instruction in EXEC
//   imem_req     out  1   fetch request to instruction memory
//   imem_addr    out  32  fetch address (== pc)
//   imem_ack     in   1   instruction memory returns imem_rdata this cycle
//   imem_rdata   in   32  fetched instruction word
//   instruction  out  32  held instruction to control_unit / datapath
//   instr_valid  out  1   instruction is valid and being executed
//   pc           out  32  address of held instruction
//   pc_plus4     out  32  pc + 4 (mod 2^32)
//   fetch_err    out  1   sticky: fetch exceeded TIMEOUT cycles
//   misalign     out  1   sticky: JR target had rs_data[1:0] != 0
// BEHAVIOUR
//   Interface: one clock; reset is asynchronous and active-low. All outputs registered except
//   imem_addr = pc and pc_plus4 = pc + 4.
//   Reset (rst=0, immediate): state=IDLE, pc=RESET_PC, instruction=0, instr_valid=0,
//   imem_req=0, fetch_err=0, misalign=0, wait counter=0.
//   FSM IDLE -> FETCH -> EXEC -> FETCH ...
//   - IDLE: one cycle after reset release; imem_req=0; next state FETCH.
//   - FETCH: imem_req=1, imem_addr=pc, held stable until ack.
//     On an edge with imem_ack=1: instruction<=imem_rdata, instr_valid<=1, imem_req<=0,
//     state<=EXEC, wait counter<=0.
//     Otherwise the wait counter increments (saturating). When it reaches TIMEOUT, fetch_err<=1.
//     Keep requesting after timeout; never abort.
//   - EXEC: instruction/pc stable; pc_control sampled only at the rising edge, after
//     control_unit's settle delay.
//     If stall=1: stay in EXEC; no register changes.
//     If stall=0: pc<=next_pc, instr_valid<=0, state<=FETCH (req rises next cycle).
//   next_pc, computed from the held instruction:
//     seq/4..15: pc_plus4
//     J:         {pc_plus4[31:28], instruction[25:0], 2'b00}
//     JR:        {rs_data[31:2], 2'b00}; misalign<=1 if rs_data[1:0]!=0
//     branch:    pc_plus4 + ({{14{instruction[15]}}, instruction[15:0], 2'b00})
//   Arithmetic is 32-bit modulo 2^32: 0xFFFFFFFC + 4 wraps to 0 without error.
//   imem_ack outside FETCH is ignored. A fetch takes >=1 cycle of req; minimum cycle per
//   instruction is 2 (FETCH w/ ack, EXEC).
//   Reset mid-fetch or mid-EXEC: imem_req and instr_valid drop combinationally-fast (async);
//   any pending ack is discarded.
//   Each sticky flag is cleared only by reset.
// TESTING
//   1 RESET_PC=0x00400000; release rst -> 1 cycle req=0, then req=1 addr=0x00400000;
//     ack rdata=0x20080005 -> instruction=0x20080005, instr_valid=1; pc_control=0 -> addr 0x00400004.
//   2 pc=0x00400008, instr=0x08100010, pc_control=1 -> next imem_addr=0x00400040.
//   3 pc=0x00400010, instr=0x1000FFFE, pc_control=3 -> next imem_addr=0x0040000C;
//     pc_control=5 -> 0x00400014.
//   4 JR: rs_data=0x00400023, pc_control=2 -> imem_addr=0x00400020, misalign=1 and remains 1.
//   5 stall=1 for 3 EXEC cycles -> pc, instruction, instr_valid unchanged, req=0;
//     pc=0xFFFFFFFC seq -> addr 0x00000000.
//   6 TIMEOUT=8, withhold ack -> fetch_err=1 after 8 FETCH cycles, req stays 1;
//     assert rst mid-FETCH -> req=0, fetch_err=0 immediately.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch stage: fetches over a req/ack handshake,
// holds the instruction for decode, then steps the PC from control_unit's pc_control.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int          TIMEOUT  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  pc_control,
  input  logic [31:0] rs_data,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_err,
  output logic        misalign
);

  localparam int             CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  TMAX = CW'(TIMEOUT);

  localparam logic [3:0] CTL_J      = 4'd1;
  localparam logic [3:0] CTL_JR     = 4'd2;
  localparam logic [3:0] CTL_BRANCH = 4'd3;

  typedef enum logic [1:0] {
    STATE_IDLE  = 2'd0,
    STATE_FETCH = 2'd1,
    STATE_EXEC  = 2'd2
  } state_t;

  state_t         state_reg;
  logic [31:0]    pc_reg;
  logic [31:0]    instr_reg;
  logic           instr_valid_reg;
  logic           imem_req_reg;
  logic           fetch_err_reg;
  logic           misalign_reg;
  logic [CW-1:0]  wait_cnt_reg;
  logic [31:0]    pc_plus4_next;
  logic [31:0]    branch_off;
  logic [31:0]    pc_next;

  assign pc_plus4_next = pc_reg + 32'd4;
  assign branch_off    = {{14{instr_reg[15]}}, instr_reg[15:0], 2'b00};

  // Codes 0 and 4..15 all fall through to sequential execution.
  always_comb begin
    pc_next = pc_plus4_next;
    case (pc_control)
      CTL_J:      pc_next = {pc_plus4_next[31:28], instr_reg[25:0], 2'b00};
      CTL_JR:     pc_next = {rs_data[31:2], 2'b00};
      CTL_BRANCH: pc_next = pc_plus4_next + branch_off;
      default:    pc_next = pc_plus4_next;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= STATE_IDLE;
      pc_reg          <= RESET_PC;
      instr_reg       <= 32'd0;
      instr_valid_reg <= 1'b0;
      imem_req_reg    <= 1'b0;
      fetch_err_reg   <= 1'b0;
      misalign_reg    <= 1'b0;
      wait_cnt_reg    <= '0;
    end else begin
      case (state_reg)
        STATE_IDLE: begin
          state_reg    <= STATE_FETCH;
          imem_req_reg <= 1'b1;
        end
        STATE_FETCH: begin
          if (imem_ack) begin
            instr_reg       <= imem_rdata;
            instr_valid_reg <= 1'b1;
            imem_req_reg    <= 1'b0;
            state_reg       <= STATE_EXEC;
            wait_cnt_reg    <= '0;
          end else begin
            // Request stays up after a timeout; the flag only reports it.
            if (wait_cnt_reg != TMAX)
              wait_cnt_reg <= wait_cnt_reg + 1'b1;
            if (wait_cnt_reg >= TMAX - 1'b1)
              fetch_err_reg <= 1'b1;
          end
        end
        STATE_EXEC: begin
          if (!stall) begin
            pc_reg          <= pc_next;
            instr_valid_reg <= 1'b0;
            imem_req_reg    <= 1'b1;
            state_reg       <= STATE_FETCH;
            if (pc_control == CTL_JR && rs_data[1:0] != 2'b00)
              misalign_reg <= 1'b1;
          end
        end
        default: begin
          state_reg    <= STATE_IDLE;
          imem_req_reg <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_reg;
  assign imem_addr   = pc_reg;
  assign instruction = instr_reg;
  assign instr_valid = instr_valid_reg;
  assign pc          = pc_reg;
  assign pc_plus4    = pc_plus4_next;
  assign fetch_err   = fetch_err_reg;
  assign misalign    = misalign_reg;

endmodule
